// File: rtl/mgt_02_div_unit.sv
// Iterative restoring radix-2 integer divider for DIV/DIVU/REM/REMU.
// Handshake: a request is taken on a clock edge where valid_i & ready_o & clk_en_i & !kill_i; valid_o pulses once per completed request.
module mgt_02_div_unit #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clk_en_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             kill_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             div_by_zero_o,
  output logic             busy_o,
  output logic [2:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_dbz;

  logic             w_signed;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_div0;
  logic             w_ovf;
  logic             w_early;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_signed  = ~r_op[0];
  assign w_dvd_neg = w_signed & r_dvd[WIDTH-1];
  assign w_dvs_neg = w_signed & r_dvs[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~r_dvd + ONE) : r_dvd;
  assign w_dvs_mag = w_dvs_neg ? (~r_dvs + ONE) : r_dvs;
  assign w_div0    = (r_dvs == '0);
  assign w_ovf     = w_signed && (r_dvd == MIN_NEG) && (r_dvs == '1);
  assign w_early   = EARLY_OUT && (w_dvd_mag < w_dvs_mag);

  // r_quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_quo_fix = r_q_neg ? (~r_quo + ONE) : r_quo;
  assign w_rem_fix = r_r_neg ? (~r_rem + ONE) : r_rem;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else if (clk_en_i) begin
      r_valid <= 1'b0;
      if (kill_i) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (valid_i) begin
              r_op    <= op_i;
              r_dvd   <= dividend_i;
              r_dvs   <= divisor_i;
              r_state <= S_PREP;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_PREP: begin
            r_q_neg <= w_dvd_neg ^ w_dvs_neg;
            r_r_neg <= w_dvd_neg;
            r_quo   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_rem   <= '0;
            if (w_div0) begin
              r_result <= r_op[1] ? r_dvd : '1;
              r_dbz    <= 1'b1;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              r_result <= r_op[1] ? '0 : r_dvd;
              r_dbz    <= 1'b0;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_early) begin
              r_result <= r_op[1] ? r_dvd : '0;
              r_dbz    <= 1'b0;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt   <= CW'(WIDTH);
              r_state <= S_ITER;
            end
          end
          S_ITER: begin
            if (w_trial[WIDTH]) begin
              r_rem <= w_shift[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end else begin
              r_rem <= w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
            r_dbz    <= 1'b0;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign ready_o       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy_o        = !ready_o;
  assign valid_o       = r_valid;
  assign result_o      = r_result;
  assign div_by_zero_o = r_dbz;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_mgt_02_div_unit.sv
// Directed scoreboard bench: three divider instances (32-bit early-out, 32-bit always-iterate, 8-bit).
module tb_mgt_02_div_unit;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clk_en, kill;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        v_in [3];
  logic        rdy0, rdy1, rdy2, vo0, vo1, vo2, dz0, dz1, dz2, bz0, bz1, bz2;
  logic [31:0] r0, r1;
  logic [7:0]  r2;
  logic [2:0]  st0, st1, st2;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mgt_02_div_unit #(.WIDTH(32), .EARLY_OUT(1'b1)) u_eo (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .valid_i(v_in[0]), .ready_o(rdy0),
    .op_i(op), .dividend_i(a), .divisor_i(b), .kill_i(kill), .valid_o(vo0),
    .result_o(r0), .div_by_zero_o(dz0), .busy_o(bz0), .dbg_state_o(st0));

  mgt_02_div_unit #(.WIDTH(32), .EARLY_OUT(1'b0)) u_noeo (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .valid_i(v_in[1]), .ready_o(rdy1),
    .op_i(op), .dividend_i(a), .divisor_i(b), .kill_i(kill), .valid_o(vo1),
    .result_o(r1), .div_by_zero_o(dz1), .busy_o(bz1), .dbg_state_o(st1));

  mgt_02_div_unit #(.WIDTH(8), .EARLY_OUT(1'b1)) u_w8 (
    .clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .valid_i(v_in[2]), .ready_o(rdy2),
    .op_i(op), .dividend_i(a[7:0]), .divisor_i(b[7:0]), .kill_i(kill), .valid_o(vo2),
    .result_o(r2), .div_by_zero_o(dz2), .busy_o(bz2), .dbg_state_o(st2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor side: pop the oldest expectation for this instance and compare.
  task automatic on_done(input int sel, input logic [31:0] res, input logic dbz);
    exp_t e;
    int   sz;
    sz = (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_valid dut%0d: got result %h with nothing expected (cycle %0d)", sel, res, cyc);
    end else begin
      if (sel == 0) e = q0.pop_front();
      else if (sel == 1) e = q1.pop_front();
      else e = q2.pop_front();
      chk($sformatf("result dut%0d", sel), res, e.res);
      chk($sformatf("div_by_zero dut%0d", sel), {31'b0, dbz}, {31'b0, e.dbz});
      chk($sformatf("latency dut%0d", sel), cyc - e.acc, e.lat);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && clk_en) begin
      if (vo0) on_done(0, r0, dz0);
      if (vo1) on_done(1, r1, dz1);
      if (vo2) on_done(2, {24'b0, r2}, dz2);
    end
  end

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  endfunction

  // Driver: present one request for a single cycle; optionally record the expectation.
  task automatic issue(input int sel, input logic [1:0] o, input logic [31:0] da, input logic [31:0] db,
                       input logic [31:0] er, input logic ed, input int el, input bit track, input bit sync);
    exp_t e;
    if (sync) @(negedge clk);
    chk($sformatf("ready_at_issue dut%0d", sel), {31'b0, rdy_of(sel)}, 32'd1);
    op = o;
    a = da;
    b = db;
    v_in[sel] = 1'b1;
    if (track) begin
      e.res = er;
      e.dbz = ed;
      e.acc = cyc;
      e.lat = el;
      if (sel == 0) q0.push_back(e);
      else if (sel == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    @(negedge clk);
    v_in[sel] = 1'b0;
  endtask

  task automatic wait_all();
    int i;
    for (i = 0; i < 200 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_timeout: got %0d results outstanding expected 0", q0.size() + q1.size() + q2.size());
      q0.delete();
      q1.delete();
      q2.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ready"}, {31'b0, rdy0}, 32'd1);
    chk({tag, " busy"}, {31'b0, bz0}, 32'd0);
    chk({tag, " valid"}, {31'b0, vo0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    kill = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    for (int i = 0; i < 3; i++) v_in[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk_idle_outputs("reset");
    chk("reset result", r0, 32'd0);
    chk("reset div_by_zero", {31'b0, dz0}, 32'd0);
    chk("reset result w8", {24'b0, r2}, 32'd0);

    issue(0, DIV,  32'd100,         32'd5,          32'd20,         1'b0, 35, 1, 1); wait_all();
    issue(0, REM,  32'd900,         32'd5,          32'd0,          1'b0, 35, 1, 1); wait_all();
    issue(0, DIV,  -32'sd80,        32'd5,          32'hFFFFFFF0,   1'b0, 35, 1, 1); wait_all();
    issue(0, REM,  -32'sd402,       32'd5,          32'hFFFFFFFE,   1'b0, 35, 1, 1); wait_all();
    issue(0, DIV,  -32'sd80,        32'd0,          32'hFFFFFFFF,   1'b1, 2,  1, 1); wait_all();
    issue(0, REMU, 32'd7,           32'd0,          32'd7,          1'b1, 2,  1, 1); wait_all();
    issue(0, DIV,  32'h80000000,    32'hFFFFFFFF,   32'h80000000,   1'b0, 2,  1, 1); wait_all();
    issue(0, REM,  32'h80000000,    32'hFFFFFFFF,   32'd0,          1'b0, 2,  1, 1); wait_all();
    issue(0, DIVU, 32'hFFFFFFDF,    32'd8,          32'h1FFFFFFB,   1'b0, 35, 1, 1); wait_all();
    issue(0, DIVU, 32'd0,           32'd8,          32'd0,          1'b0, 2,  1, 1); wait_all();
    issue(1, DIVU, 32'd0,           32'd8,          32'd0,          1'b0, 35, 1, 1); wait_all();
    issue(0, REM,  -32'sd3,         32'd7,          32'hFFFFFFFD,   1'b0, 2,  1, 1); wait_all();
    issue(0, DIV,  -32'sd3,         32'd7,          32'd0,          1'b0, 2,  1, 1); wait_all();

    // Back-to-back: second request accepted in the DONE cycle of the first.
    issue(0, REMU, 32'd1000, 32'd7, 32'd6, 1'b0, 35, 1, 1);
    for (int i = 0; i < 100 && !vo0; i++) @(negedge clk);
    issue(0, DIVU, 32'd1000, 32'd7, 32'h8E, 1'b0, 35, 1, 0);
    wait_all();

    // Kill on the 10th ITER cycle: no completion may follow.
    issue(0, DIV, 32'd100, 32'd5, 32'd0, 1'b0, 0, 0, 1);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk_idle_outputs("after_kill");
    repeat (40) @(negedge clk);

    // Five stalled cycles during ITER stretch latency by five.
    issue(0, DIV, 32'd100, 32'd5, 32'd20, 1'b0, 40, 1, 1);
    repeat (5) @(negedge clk);
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    clk_en = 1'b1;
    wait_all();

    // Reset mid-ITER returns every output to its reset value.
    issue(0, DIVU, 32'hFFFFFFDF, 32'd8, 32'd0, 1'b0, 0, 0, 1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("after_reset");
    chk("after_reset result", r0, 32'd0);
    chk("after_reset div_by_zero", {31'b0, dz0}, 32'd0);
    repeat (40) @(negedge clk);

    issue(2, DIV, 32'h80, 32'hFF, 32'h80, 1'b0, 2,  1, 1); wait_all();
    issue(2, DIV, 32'hF9, 32'h02, 32'hFD, 1'b0, 11, 1, 1); wait_all();
    issue(2, REM, 32'hF9, 32'h02, 32'hFF, 1'b0, 11, 1, 1); wait_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
